// File: rtl/vram_fetch_arbiter.sv
// vram_fetch_arbiter: shares one single-port video RAM between the display
// word fetch (always first) and CPU writes (idle slots only). A 2-entry
// prefetch FIFO behind the pixel_row register hides the 1-cycle RAM latency.
// All bus strobes are registered: mem_rd/mem_we are visible the cycle after
// the decision and the RAM returns read data the cycle after mem_rd.
// Optional build macro FRAME_RESYNC_EN: on a misaligned frame boundary, flush
// the prefetch path and restart the fetch at word 0.
module vram_fetch_arbiter #(
    parameter int ADDR_W      = 15,
    parameter int FRAME_WORDS = 30000,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic              CLK_VGA,
    input  logic              reset,
    input  logic              newData,
    input  logic              end_of_line,
    input  logic              end_of_frame,
    output logic [15:0]       pixel_row,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic              underrun,
    output logic              desync
);

    typedef enum logic [1:0] {PRIME_RD, PRIME_CAP, IDLE} state_t;

    state_t            state;
    logic [1:0][15:0]  fifo;       // [0] is the head
    logic [1:0][15:0]  fifo_n;
    logic [1:0]        count;
    logic [1:0]        count_n;
    logic [1:0]        wr_idx;
    logic              rd_vld;     // mem_rdata carries a display word this cycle
    logic [ADDR_W-1:0] disp_addr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              pop;
    logic              push;
    logic [2:0]        occ;
    logic              issue_rd;
    logic              serve_cpu;
    logic              frame_bad;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(FRAME_WORDS - 1)) ? '0 : a + 1'b1;
    endfunction

    // Slot arbitration and next FIFO contents. Occupancy discounts this
    // cycle's pop so a consumed word is refilled before the CPU gets the bus.
    always_comb begin
        pop       = newData && (count != 2'd0);
        push      = rd_vld && (state == IDLE);
        occ       = 3'(count) + 3'(mem_rd) + 3'(rd_vld) - 3'(pop);
        issue_rd  = (state == IDLE) && (occ < 3'(FIFO_DEPTH));
        // cpu_ack high means the current request is the one just served
        serve_cpu = (state == IDLE) && !issue_rd && cpu_req && !cpu_ack;
        frame_bad = end_of_line && end_of_frame && (rd_ptr != '0);
        fifo_n    = fifo;
        if (pop)
            fifo_n[0] = fifo[1];
        wr_idx = count - 2'(pop);
        if (push) begin
            if (wr_idx == 2'd0)
                fifo_n[0] = mem_rdata;
            else
                fifo_n[1] = mem_rdata;
        end
        count_n = count - 2'(pop) + 2'(push);
    end

    // Fetch FSM, FIFO, bus strobes and sticky status flags.
    always_ff @(posedge CLK_VGA) begin
        if (!reset) begin
            state     <= PRIME_RD;
            fifo      <= '0;
            count     <= 2'd0;
            rd_vld    <= 1'b0;
            disp_addr <= '0;
            rd_ptr    <= '0;
            pixel_row <= 16'h0000;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 16'h0000;
            cpu_ack   <= 1'b0;
            underrun  <= 1'b0;
            desync    <= 1'b0;
        end else begin
            mem_rd  <= 1'b0;
            mem_we  <= 1'b0;
            cpu_ack <= 1'b0;
            rd_vld  <= mem_rd;
            fifo    <= fifo_n;
            count   <= count_n;

            if (frame_bad)
                desync <= 1'b1;

            if (newData && (count == 2'd0)) begin
                underrun  <= 1'b1;
                pixel_row <= 16'h0000;
            end
            if (pop) begin
                pixel_row <= fifo[0];
                rd_ptr    <= wrap_inc(rd_ptr);
            end

            case (state)
                PRIME_RD: begin
                    mem_rd    <= 1'b1;
                    mem_addr  <= disp_addr;
                    disp_addr <= wrap_inc(disp_addr);
                    state     <= PRIME_CAP;
                end
                PRIME_CAP: begin
                    // the first word goes straight to the display register
                    if (rd_vld) begin
                        pixel_row <= mem_rdata;
                        rd_ptr    <= wrap_inc(rd_ptr);
                        state     <= IDLE;
                    end
                end
                default: begin
                    if (issue_rd) begin
                        mem_rd    <= 1'b1;
                        mem_addr  <= disp_addr;
                        disp_addr <= wrap_inc(disp_addr);
                    end else if (serve_cpu) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        cpu_ack   <= 1'b1;
                    end
                end
            endcase

`ifdef FRAME_RESYNC_EN
            // Drop everything prefetched (including a read in flight) and
            // reissue word 0 right away; pixel_row keeps stale data until then.
            if (frame_bad) begin
                count     <= 2'd0;
                rd_vld    <= 1'b0;
                rd_ptr    <= '0;
                mem_rd    <= 1'b1;
                mem_we    <= 1'b0;
                cpu_ack   <= 1'b0;
                mem_addr  <= '0;
                disp_addr <= wrap_inc('0);
                state     <= PRIME_CAP;
            end
`endif
        end
    end

endmodule
